// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and helpers for the two-port data-RAM arbiter:
//   state_t     - arbiter FSM states (IDLE, WAIT, RESP)
//   port_id_t   - requester identity (PORT_A = CPU, PORT_B = loader/debug)
//   merge_bytes - byte-lane merge used for read-modify-write of partial stores
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    localparam logic [3:0] WSTRB_READ = 4'h0;
    localparam logic [3:0] WSTRB_FULL = 4'hF;

    // Byte i of the result comes from wdata when wstrb[i] is set, otherwise
    // from the word currently stored in the RAM.
    function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                                input logic [31:0] old_word,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports, the RAM port and the busy flag.
//   a_* / b_*   : valid/ready request ports (addr, wdata, wstrb in; rdata out)
//   mem_*       : single-port synchronous RAM (en, we, word addr, wdata, rdata)
//   busy        : arbiter not in IDLE
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters + RAM)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_BITS = 11
);
    logic                 a_valid;
    logic                 a_ready;
    logic [31:0]          a_addr;
    logic [31:0]          a_wdata;
    logic [3:0]           a_wstrb;
    logic [31:0]          a_rdata;

    logic                 b_valid;
    logic                 b_ready;
    logic [31:0]          b_addr;
    logic [31:0]          b_wdata;
    logic [3:0]           b_wstrb;
    logic [31:0]          b_rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-3:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    logic                 busy;

    modport slave (
        input  a_valid, a_addr, a_wdata, a_wstrb,
        output a_ready, a_rdata,
        input  b_valid, b_addr, b_wdata, b_wstrb,
        output b_ready, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output a_valid, a_addr, a_wdata, a_wstrb,
        input  a_ready, a_rdata,
        output b_valid, b_addr, b_wdata, b_wstrb,
        input  b_ready, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter granting one of two requesters (A = CPU, B = loader)
// access to a single-port, one-cycle-latency data RAM.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : dmem_arbiter_if.slave (request ports A/B, RAM port, busy)
// Transaction timing (grant cycle = 0):
//   full write  : RAM write in cycle 0, ready in cycle 1
//   read        : RAM read in cycle 0, data captured in cycle 1, ready cycle 2
//   partial     : RAM read in cycle 0, merged write in cycle 1, ready cycle 2
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 11
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int IDX_W = ADDR_BITS - 2;

    state_t             state;
    port_id_t           gnt_port;
    port_id_t           last_port;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_wstrb;
    logic [31:0]        rdata_q;

    logic               req_any;
    port_id_t           pick;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_wstrb;

    // Region decoding happens outside; these bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.a_addr[31:ADDR_BITS], bus.a_addr[1:0],
                                bus.b_addr[31:ADDR_BITS], bus.b_addr[1:0]};

    // Arbitration: on contention the port not served last wins.
    always_comb begin
        req_any = bus.a_valid | bus.b_valid;
        if (bus.a_valid && bus.b_valid) begin
            pick = (last_port == PORT_A) ? PORT_B : PORT_A;
        end else if (bus.a_valid) begin
            pick = PORT_A;
        end else begin
            pick = PORT_B;
        end
        if (pick == PORT_A) begin
            sel_addr  = bus.a_addr;
            sel_wdata = bus.a_wdata;
            sel_wstrb = bus.a_wstrb;
        end else begin
            sel_addr  = bus.b_addr;
            sel_wdata = bus.b_wdata;
            sel_wstrb = bus.b_wstrb;
        end
    end

    // RAM and handshake outputs. Everything is gated by reset so that an
    // aborted transaction neither writes the RAM nor pulses ready.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = lat_idx;
        bus.mem_wdata = lat_wdata;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_addr  = sel_addr[ADDR_BITS-1:2];
                        bus.mem_we    = (sel_wstrb == WSTRB_FULL);
                        bus.mem_wdata = sel_wdata;
                    end
                end
                ST_WAIT: begin
                    // Reads only capture data here; partial writes commit the merge.
                    if (lat_wstrb != WSTRB_READ) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = 1'b1;
                        bus.mem_wdata = merge_bytes(lat_wdata, bus.mem_rdata, lat_wstrb);
                    end
                end
                ST_RESP: begin
                    bus.a_ready = (gnt_port == PORT_A);
                    bus.b_ready = (gnt_port == PORT_B);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a_rdata = rdata_q;
    assign bus.b_rdata = rdata_q;
    assign bus.busy    = (state != ST_IDLE);

    // Control state
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt_port  <= PORT_A;
            last_port <= PORT_B;
            rdata_q   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        gnt_port <= pick;
                        state    <= (sel_wstrb == WSTRB_FULL) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_wstrb == WSTRB_READ) begin
                        rdata_q <= bus.mem_rdata;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    last_port <= gnt_port;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request capture at grant; requester inputs are ignored afterwards.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && req_any) begin
            lat_idx   <= sel_addr[ADDR_BITS-1:2];
            lat_wdata <= sel_wdata;
            lat_wstrb <= sel_wstrb;
        end
    end

endmodule
